// File: rtl/bf_program_loader.sv
// Streams Brainfuck source text into program memory as 3-bit opcodes, checking bracket balance,
// nesting depth and program capacity. Terminates in DONE or in a sticky ERROR with a cause code.
module bf_program_loader #(
   parameter int unsigned PROGRAM_LENGTH = 9,
   parameter int unsigned MAX_DEPTH      = 15
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [7:0]                           src_byte,
   input  logic                                 src_valid,
   input  logic                                 src_last,
   output logic                                 src_ready,
   output logic                                 prog_wr_en,
   output logic [$clog2(PROGRAM_LENGTH)-1:0]    prog_wr_addr,
   output logic [2:0]                           prog_wr_data,
   output logic [$clog2(PROGRAM_LENGTH+1)-1:0]  prog_length,
   output logic                                 done,
   output logic [2:0]                           error
);

   localparam int unsigned AW = $clog2(PROGRAM_LENGTH);
   localparam int unsigned CW = $clog2(PROGRAM_LENGTH + 1);
   localparam int unsigned DW = $clog2(MAX_DEPTH + 1);

   localparam logic [CW-1:0] LP_FULL      = CW'(PROGRAM_LENGTH);
   localparam logic [DW-1:0] LP_MAX_DEPTH = DW'(MAX_DEPTH);

   localparam logic [2:0] OP_OPEN  = 3'd6;
   localparam logic [2:0] OP_CLOSE = 3'd7;

   localparam logic [2:0] ERR_NONE      = 3'd0;
   localparam logic [2:0] ERR_UNMATCHED = 3'd1;
   localparam logic [2:0] ERR_UNCLOSED  = 3'd2;
   localparam logic [2:0] ERR_PROG_OVF  = 3'd3;
   localparam logic [2:0] ERR_DEPTH_OVF = 3'd4;

   typedef enum logic [1:0] {
      StLoad,
      StDone,
      StError
   } state_t;

   state_t          r_state;
   logic [CW-1:0]   r_count;
   logic [DW-1:0]   r_depth;
   logic            r_wr_en;
   logic [AW-1:0]   r_wr_addr;
   logic [2:0]      r_wr_data;
   logic [2:0]      r_error;

   state_t          w_state_nxt;
   logic [CW-1:0]   w_count_nxt;
   logic [DW-1:0]   w_depth_nxt;
   logic            w_wr_en_nxt;
   logic [AW-1:0]   w_wr_addr_nxt;
   logic [2:0]      w_wr_data_nxt;
   logic [2:0]      w_error_nxt;

   logic            w_accept;
   logic            w_is_cmd;
   logic [2:0]      w_opcode;
   logic            w_fault;
   logic [2:0]      w_fault_code;

   always_comb begin
      w_is_cmd = 1'b1;
      w_opcode = 3'd0;
      case (src_byte)
         "+":     w_opcode = 3'd0;
         "-":     w_opcode = 3'd1;
         ">":     w_opcode = 3'd2;
         "<":     w_opcode = 3'd3;
         ".":     w_opcode = 3'd4;
         ",":     w_opcode = 3'd5;
         "[":     w_opcode = OP_OPEN;
         "]":     w_opcode = OP_CLOSE;
         default: w_is_cmd = 1'b0;
      endcase
   end

   assign w_accept = src_valid && src_ready;

   // Capacity is checked before bracket legality, so a full program reports overflow first.
   always_comb begin
      w_fault      = 1'b0;
      w_fault_code = ERR_NONE;
      if (w_is_cmd) begin
         if (r_count == LP_FULL) begin
            w_fault      = 1'b1;
            w_fault_code = ERR_PROG_OVF;
         end else if ((w_opcode == OP_CLOSE) && (r_depth == '0)) begin
            w_fault      = 1'b1;
            w_fault_code = ERR_UNMATCHED;
         end else if ((w_opcode == OP_OPEN) && (r_depth == LP_MAX_DEPTH)) begin
            w_fault      = 1'b1;
            w_fault_code = ERR_DEPTH_OVF;
         end
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_count_nxt   = r_count;
      w_depth_nxt   = r_depth;
      w_wr_en_nxt   = 1'b0;
      w_wr_addr_nxt = '0;
      w_wr_data_nxt = 3'd0;
      w_error_nxt   = r_error;

      if (w_accept) begin
         if (w_is_cmd && !w_fault) begin
            w_wr_en_nxt   = 1'b1;
            w_wr_addr_nxt = AW'(r_count);
            w_wr_data_nxt = w_opcode;
            w_count_nxt   = r_count + CW'(1);
            if (w_opcode == OP_OPEN) begin
               w_depth_nxt = r_depth + DW'(1);
            end else if (w_opcode == OP_CLOSE) begin
               w_depth_nxt = r_depth - DW'(1);
            end
         end

         // A character's own fault outranks the unclosed-bracket check on src_last.
         if (w_fault) begin
            w_state_nxt = StError;
            w_error_nxt = w_fault_code;
         end else if (src_last) begin
            if (w_depth_nxt == '0) begin
               w_state_nxt = StDone;
            end else begin
               w_state_nxt = StError;
               w_error_nxt = ERR_UNCLOSED;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= StLoad;
         r_count   <= '0;
         r_depth   <= '0;
         r_wr_en   <= 1'b0;
         r_wr_addr <= '0;
         r_wr_data <= 3'd0;
         r_error   <= ERR_NONE;
      end else begin
         r_state   <= w_state_nxt;
         r_count   <= w_count_nxt;
         r_depth   <= w_depth_nxt;
         r_wr_en   <= w_wr_en_nxt;
         r_wr_addr <= w_wr_addr_nxt;
         r_wr_data <= w_wr_data_nxt;
         r_error   <= w_error_nxt;
      end
   end

   // rst gates the write port so a write registered just before reset never reaches memory.
   assign src_ready    = (r_state == StLoad) && !rst;
   assign prog_wr_en   = r_wr_en && !rst;
   assign prog_wr_addr = rst ? '0 : r_wr_addr;
   assign prog_wr_data = rst ? 3'd0 : r_wr_data;
   assign prog_length  = r_count;
   assign done         = (r_state == StDone);
   assign error        = r_error;

endmodule
